// File: rtl/lcd_rx.sv
// Receiver for a 4-bit HD44780-style LCD bus: synchronizes the pins, qualifies E strobes,
// reassembles nibbles into bytes and tracks the panel's 8-bit/4-bit interface mode.
module lcd_rx #(
    parameter int MIN_E_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    output logic [7:0] byte_out,
    output logic       rs_out,
    output logic       valid,
    output logic       mode_4bit,
    output logic       nibble_pending,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int EW = $clog2(MIN_E_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE8, IDLE4, HALF4} state_t;

    logic          e_s1_q, e_s2_q, e_s3_q;
    logic          rs_s1_q, rs_s2_q;
    logic [3:0]    d_s1_q, d_s2_q;
    logic [EW-1:0] wcnt_q;
    logic          stb_q, short_q, ev_rs_q;
    logic [3:0]    ev_d_q;

    state_t        state_q, state_d;
    logic [3:0]    hi_q, hi_d;
    logic          rs_lat_q, rs_lat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_out_q, rs_out_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic fall, width_ok;
    assign fall     = e_s3_q & ~e_s2_q;
    assign width_ok = (wcnt_q >= EW'(MIN_E_CYCLES));

    // Synchronizers, E width counter and a registered strobe event with its captured data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_s1_q  <= 1'b0;
            e_s2_q  <= 1'b0;
            e_s3_q  <= 1'b0;
            rs_s1_q <= 1'b0;
            rs_s2_q <= 1'b0;
            d_s1_q  <= 4'h0;
            d_s2_q  <= 4'h0;
            wcnt_q  <= '0;
            stb_q   <= 1'b0;
            short_q <= 1'b0;
            ev_rs_q <= 1'b0;
            ev_d_q  <= 4'h0;
        end else begin
            e_s1_q  <= lcd_e;
            e_s2_q  <= e_s1_q;
            e_s3_q  <= e_s2_q;
            rs_s1_q <= lcd_rs;
            rs_s2_q <= rs_s1_q;
            d_s1_q  <= lcd_data;
            d_s2_q  <= d_s1_q;
            if (!e_s2_q)
                wcnt_q <= '0;
            else if (!width_ok)
                wcnt_q <= wcnt_q + EW'(1);
            stb_q   <= fall & width_ok;
            short_q <= fall & ~width_ok;
            if (fall) begin
                ev_rs_q <= rs_s2_q;
                ev_d_q  <= d_s2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE8;
            hi_q     <= 4'h0;
            rs_lat_q <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= 8'h00;
            rs_out_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            rs_lat_q <= rs_lat_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            rs_out_q <= rs_out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        rs_lat_d = rs_lat_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        rs_out_d = rs_out_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        if (state_q == HALF4 && tmo_q != TW'(TIMEOUT_CYCLES))
            tmo_d = tmo_q + TW'(1);

        // Short pulses only flag an error; they never touch the FSM or the timeout
        if (short_q) begin
            err_d  = 1'b1;
            code_d = 2'b01;
        end

        if (stb_q) begin
            case (state_q)
                IDLE8: begin
                    byte_d   = {ev_d_q, 4'h0};
                    rs_out_d = ev_rs_q;
                    valid_d  = 1'b1;
                    if (!ev_rs_q && ev_d_q == 4'h2)
                        state_d = IDLE4;
                end
                IDLE4: begin
                    hi_d     = ev_d_q;
                    rs_lat_d = ev_rs_q;
                    tmo_d    = '0;
                    state_d  = HALF4;
                end
                HALF4: begin
                    if (ev_rs_q == rs_lat_q) begin
                        byte_d   = {hi_q, ev_d_q};
                        rs_out_d = ev_rs_q;
                        valid_d  = 1'b1;
                        state_d  = (!ev_rs_q && hi_q == 4'h3) ? IDLE8 : IDLE4;
                    end else begin
                        err_d    = 1'b1;
                        code_d   = 2'b10;
                        hi_d     = ev_d_q;
                        rs_lat_d = ev_rs_q;
                        tmo_d    = '0;
                    end
                end
                default: state_d = IDLE8;
            endcase
        end else if (state_q == HALF4 && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = IDLE4;
        end
    end

    assign byte_out       = byte_q;
    assign rs_out         = rs_out_q;
    assign valid          = valid_q;
    assign err            = err_q;
    assign err_code       = code_q;
    assign mode_4bit      = (state_q != IDLE8);
    assign nibble_pending = (state_q == HALF4);
endmodule
